light_sequencer: RTL and testbench

//  Upstream stage of scp_079: generates the one-hot green/yellow/red light pattern that scp_079 samples.

---
 rtl/light_pkg.sv | 40 ++++
 rtl/phase_counter.sv | 27 ++
 rtl/light_sequencer.sv | 99 +++++++++
 tb/tb_light_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types and helpers for the traffic-light sequencer: phase encoding,
// timer width, and per-phase reload/decode functions.
package light_pkg;

  localparam int unsigned TIMER_W = 6;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_RED    = 2'd2
  } state_e;

  // Reload value (duration minus one) for the phase being entered.
  function automatic logic [TIMER_W-1:0] dur_of(state_e s, int unsigned g,
                                                int unsigned y, int unsigned r);
    case (s)
      S_YELLOW: dur_of = TIMER_W'(y - 1);
      S_RED:    dur_of = TIMER_W'(r - 1);
      default:  dur_of = TIMER_W'(g - 1);
    endcase
  endfunction

  function automatic state_e next_of(state_e s);
    case (s)
      S_GREEN:  next_of = S_YELLOW;
      S_YELLOW: next_of = S_RED;
      default:  next_of = S_GREEN;
    endcase
  endfunction

  // One-hot light vector ordered {red, yellow, green}.
  function automatic logic [2:0] onehot_of(state_e s);
    case (s)
      S_YELLOW: onehot_of = 3'b010;
      S_RED:    onehot_of = 3'b100;
      default:  onehot_of = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter for phase timing; saturates at zero and can be frozen.
module phase_counter
  import light_pkg::*;
(
  input  logic               clock,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  input  logic               freeze,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (load) begin
      count_q <= load_val;
    end else if (dec && !freeze && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// Green/yellow/red phase sequencer with force-red and hold; lights are held in
// a register so the one-hot pattern changes cleanly on a clock edge.
module light_sequencer
  import light_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 35,
  parameter int unsigned YELLOW_CYCLES = 5,
  parameter int unsigned RED_CYCLES    = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               hold,
  input  logic               force_red,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic [TIMER_W-1:0] phase_timer,
  output logic               phase_done
);

  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 63) begin : g_bad_green
    $error("GREEN_CYCLES out of range 1..63");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 63) begin : g_bad_yellow
    $error("YELLOW_CYCLES out of range 1..63");
  end
  if (RED_CYCLES < 1 || RED_CYCLES > 63) begin : g_bad_red
    $error("RED_CYCLES out of range 1..63");
  end

  state_e             state_q, state_d;
  logic [2:0]         lights_q, lights_d;
  logic               done_q, done_d;
  logic               load, dec, freeze, zero;
  logic [TIMER_W-1:0] load_val, count;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    freeze  = 1'b0;
    done_d  = 1'b0;
    if (reset) begin
      state_d = S_GREEN;
      load    = 1'b1;
    end else if (!(state_q inside {S_GREEN, S_YELLOW, S_RED})) begin
      state_d = S_GREEN;
      load    = 1'b1;
      done_d  = 1'b1;
    end else if (force_red && state_q == S_GREEN) begin
      state_d = S_YELLOW;
      load    = 1'b1;
      done_d  = 1'b1;
    end else if ((force_red && state_q == S_RED) || hold) begin
      // force_red in YELLOW falls through to here or the normal count.
      freeze = 1'b1;
    end else if (tick) begin
      if (zero) begin
        state_d = next_of(state_q);
        load    = 1'b1;
        done_d  = 1'b1;
      end else begin
        dec = 1'b1;
      end
    end
    load_val = dur_of(state_d, GREEN_CYCLES, YELLOW_CYCLES, RED_CYCLES);
    lights_d = onehot_of(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_GREEN;
      lights_q <= 3'b001;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      done_q   <= done_d;
    end
  end

  phase_counter u_phase_counter (
    .clock    (clock),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .freeze   (freeze),
    .count    (count),
    .zero     (zero)
  );

  assign green       = lights_q[0];
  assign yellow      = lights_q[1];
  assign red         = lights_q[2];
  assign phase_timer = count;
  assign phase_done  = done_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with hand-computed expectations.
module tb_light_sequencer;

  logic       clock = 1'b0;
  logic       reset, tick, hold, force_red;
  logic       green, yellow, red, phase_done;
  logic [5:0] phase_timer;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        mon_en      = 1'b0;

  always #5 clock = ~clock;

  light_sequencer #(
    .GREEN_CYCLES  (35),
    .YELLOW_CYCLES (5),
    .RED_CYCLES    (20)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .hold        (hold),
    .force_red   (force_red),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .phase_timer (phase_timer),
    .phase_done  (phase_done)
  );

  // Packed view {green, yellow, red, phase_done, phase_timer}.
  function automatic logic [9:0] ev(logic g, logic y, logic r, logic d, logic [5:0] t);
    return {g, y, r, d, t};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {green, yellow, red, phase_done, phase_timer};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed g%b y%b r%b d%b t%0d, expected g%b y%b r%b d%b t%0d",
             tag, obs[9], obs[8], obs[7], obs[6], obs[5:0],
             exp[9], exp[8], exp[7], exp[6], exp[5:0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      vectors++;
      assert ($countones({green, yellow, red}) == 1) else begin
        miscompares++;
        $error("FAIL onehot: observed g%b y%b r%b, expected exactly one set",
               green, yellow, red);
      end
    end
  end

  initial begin
    reset = 1'b1; tick = 1'b0; hold = 1'b0; force_red = 1'b0;
    #1;

    // Basic sequencing with tick held high
    step(1);
    chk("reset", ev(1, 0, 0, 0, 6'd34));
    mon_en = 1'b1;
    reset = 1'b0; tick = 1'b1;
    step(34); chk("green_end",    ev(1, 0, 0, 0, 6'd0));
    step(1);  chk("yellow_entry", ev(0, 1, 0, 1, 6'd4));
    step(1);  chk("yellow_count", ev(0, 1, 0, 0, 6'd3));
    step(4);  chk("red_entry",    ev(0, 0, 1, 1, 6'd19));
    step(20); chk("green_again",  ev(1, 0, 0, 1, 6'd34));

    // tick toggling: count moves only on tick edges, GREEN spans 70 clocks
    reset = 1'b1; step(1); reset = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick = ((k - 1) % 2 == 1);
      step(1);
      if (k < 70) chk("tick_toggle", ev(1, 0, 0, 0, 6'(34 - k / 2)));
      else        chk("tick_toggle_yellow", ev(0, 1, 0, 1, 6'd4));
    end
    tick = 1'b0;
    step(1); chk("done_drops_no_tick", ev(0, 1, 0, 0, 6'd4));

    // force_red in GREEN cuts to YELLOW; ignored while in YELLOW
    reset = 1'b1; step(1); reset = 1'b0; tick = 1'b1;
    step(14); chk("green_t20", ev(1, 0, 0, 0, 6'd20));
    force_red = 1'b1;
    step(1); chk("force_to_yellow", ev(0, 1, 0, 1, 6'd4));
    step(2); chk("force_in_yellow", ev(0, 1, 0, 0, 6'd2));
    force_red = 1'b0;
    step(2); chk("yellow_t0",  ev(0, 1, 0, 0, 6'd0));
    step(1); chk("red_after",  ev(0, 0, 1, 1, 6'd19));

    // force_red held in RED freezes the countdown
    step(12); chk("red_t7", ev(0, 0, 1, 0, 6'd7));
    force_red = 1'b1;
    step(10); chk("red_frozen", ev(0, 0, 1, 0, 6'd7));
    force_red = 1'b0;
    step(7); chk("red_release_t0", ev(0, 0, 1, 0, 6'd0));
    step(1); chk("red_release_green", ev(1, 0, 0, 1, 6'd34));

    // hold at YELLOW timer 0 blocks the transition
    step(34); step(1); chk("yellow_again", ev(0, 1, 0, 1, 6'd4));
    step(4); chk("yellow_t0_b", ev(0, 1, 0, 0, 6'd0));
    hold = 1'b1;
    step(5); chk("hold_yellow", ev(0, 1, 0, 0, 6'd0));
    hold = 1'b0;
    step(1); chk("hold_release_red", ev(0, 0, 1, 1, 6'd19));

    // reset in the middle of RED
    step(7); chk("red_t12", ev(0, 0, 1, 0, 6'd12));
    reset = 1'b1;
    step(1); chk("mid_red_reset", ev(1, 0, 0, 0, 6'd34));
    reset = 1'b0;
    step(1); chk("post_reset_count", ev(1, 0, 0, 0, 6'd33));

    mon_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
